// File: rtl/vga_scan_controller.sv
// 640x480@60 VGA scan generator: pixel divider, raster counters, image RAM addressing and a
// two-tick sync/colour pipeline. Optional macro IMG_BORDER_EN draws a white ring around the image.
module vga_scan_controller #(
  parameter int CLK_DIV    = 4,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int IMG_X0     = 256,
  parameter int IMG_Y0     = 176,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rVGA,
  input  logic [3:0] gVGA,
  input  logic [3:0] bVGA,
  output logic [9:0] vga_addr,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int IMG_W   = 32 << SCALE_LOG2;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  localparam logic [HW-1:0] H_ACT  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] X_BEG  = HW'(IMG_X0);
  localparam logic [HW-1:0] X_END  = HW'(IMG_X0 + IMG_W);

  localparam logic [VW-1:0] V_ACT  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] Y_BEG  = VW'(IMG_Y0);
  localparam logic [VW-1:0] Y_END  = VW'(IMG_Y0 + IMG_W);

`ifdef IMG_BORDER_EN
  localparam logic [HW-1:0] X_RLO = HW'(IMG_X0 - 1);
  localparam logic [HW-1:0] X_RHI = HW'(IMG_X0 + IMG_W + 1);
  localparam logic [VW-1:0] Y_RLO = VW'(IMG_Y0 - 1);
  localparam logic [VW-1:0] Y_RHI = VW'(IMG_Y0 + IMG_W + 1);
`endif

  function automatic logic in_h(input logic [HW-1:0] c, input logic [HW-1:0] lo,
                                input logic [HW-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  function automatic logic in_v(input logic [VW-1:0] c, input logic [VW-1:0] lo,
                                input logic [VW-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  logic [DW-1:0] div_p0;
  logic [HW-1:0] h_cnt_p0;
  logic [VW-1:0] v_cnt_p0;

  logic          active_c, img_c, border_c, hs_c, vs_c;
  logic [9:0]    addr_c;

  logic          active_p1, img_p1, border_p1, hs_p1, vs_p1, vld_p1;

  // Stage 0: pixel divider and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      div_p0      <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      h_cnt_p0    <= '0;
      v_cnt_p0    <= '0;
    end else begin
      div_p0      <= (div_p0 == DIV_LAST) ? '0 : div_p0 + DW'(1);
      pix_tick    <= (div_p0 == DIV_PRE);
      frame_start <= 1'b0;
      if (pix_tick) begin
        if (h_cnt_p0 == H_LAST) begin
          h_cnt_p0 <= '0;
          if (v_cnt_p0 == V_LAST) begin
            v_cnt_p0    <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt_p0 <= v_cnt_p0 + VW'(1);
          end
        end else begin
          h_cnt_p0 <= h_cnt_p0 + HW'(1);
        end
      end
    end
  end

  // Offsets wrap outside the window but are only used when img_c holds
  always_comb begin
    active_c = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
    img_c    = in_h(h_cnt_p0, X_BEG, X_END) && in_v(v_cnt_p0, Y_BEG, Y_END);
    hs_c     = !in_h(h_cnt_p0, HS_BEG, HS_END);
    vs_c     = !in_v(v_cnt_p0, VS_BEG, VS_END);
    addr_c   = '0;
    if (img_c)
      addr_c = {5'((v_cnt_p0 - Y_BEG) >> SCALE_LOG2), 5'((h_cnt_p0 - X_BEG) >> SCALE_LOG2)};
`ifdef IMG_BORDER_EN
    border_c = ((h_cnt_p0 == X_RLO || h_cnt_p0 == X_END) && in_v(v_cnt_p0, Y_RLO, Y_RHI)) ||
               ((v_cnt_p0 == Y_RLO || v_cnt_p0 == Y_END) && in_h(h_cnt_p0, X_RLO, X_RHI));
`else
    border_c = 1'b0;
`endif
  end

  // Stage 1: window decode and RAM address
  always_ff @(posedge clk) begin
    if (rst) begin
      active_p1 <= 1'b0;
      img_p1    <= 1'b0;
      border_p1 <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
      vld_p1    <= 1'b0;
      vga_addr  <= '0;
    end else if (pix_tick) begin
      active_p1 <= active_c;
      img_p1    <= img_c;
      border_p1 <= border_c;
      hs_p1     <= hs_c;
      vs_p1     <= vs_c;
      vld_p1    <= 1'b1;
      vga_addr  <= addr_c;
    end
  end

  // Stage 2: blank colour and align it with sync at the pins
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (pix_tick) begin
      hsync <= hs_p1;
      vsync <= vs_p1;
      if (vld_p1 && active_p1 && img_p1)
        {vga_r, vga_g, vga_b} <= {rVGA, gVGA, bVGA};
      else if (vld_p1 && active_p1 && border_p1)
        {vga_r, vga_g, vga_b} <= 12'hFFF;
      else
        {vga_r, vga_g, vga_b} <= 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Self-checking bench for vga_scan_controller, run with a shrunken raster so whole frames fit.
// Expected pins come from a pixel-index model (h = n mod HT, v = n div HT) and a vector table.
module tb_vga_scan_controller;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 80, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 72, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int IMG_X0 = 6, IMG_Y0 = 4, SCALE_LOG2 = 1;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam int SC = 1 << SCALE_LOG2;
  localparam int IW = 32 * SC;
  localparam int BUDGET = 40000;
`ifdef IMG_BORDER_EN
  localparam bit RING_EN = 1'b1;
`else
  localparam bit RING_EN = 1'b0;
`endif
  localparam logic [11:0] RING = RING_EN ? 12'hFFF : 12'h000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rVGA, gVGA, bVGA;
  logic [9:0] vga_addr;
  logic       hsync, vsync, pix_tick, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_scan_controller #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0), .SCALE_LOG2(SCALE_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .rVGA(rVGA), .gVGA(gVGA), .bVGA(bVGA),
    .vga_addr(vga_addr), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_tick(pix_tick), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, k = 0;
  bit          pend = 1'b0, rand_mode = 1'b0, agg_en = 1'b0;
  logic [11:0] tick_rgb = 12'h000;
  int          hs_low = 0, vs_low = 0, fs_seen = 0;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb_in;
    logic [9:0]  addr;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;
  vec_t tbl[12];

  function automatic int px_h(input int n); return n % HT; endfunction
  function automatic int px_v(input int n); return (n / HT) % VT; endfunction

  function automatic bit in_win(input int h, input int v);
    return h >= IMG_X0 && h < IMG_X0 + IW && v >= IMG_Y0 && v < IMG_Y0 + IW;
  endfunction

  function automatic logic [9:0] m_addr(input int n);
    int h, v;
    h = px_h(n);
    v = px_v(n);
    if (!in_win(h, v)) return 10'd0;
    return 10'(((v - IMG_Y0) / SC) * 32 + (h - IMG_X0) / SC);
  endfunction

  function automatic logic m_hs(input int n);
    return !(px_h(n) >= H_VIS + H_FP && px_h(n) < H_VIS + H_FP + H_SYNC);
  endfunction

  function automatic logic m_vs(input int n);
    return !(px_v(n) >= V_VIS + V_FP && px_v(n) < V_VIS + V_FP + V_SYNC);
  endfunction

  function automatic logic [11:0] m_rgb(input int n, input logic [11:0] rgb);
    int h, v;
    bit act, ring;
    h = px_h(n);
    v = px_v(n);
    act = h < H_VIS && v < V_VIS;
    ring = RING_EN &&
           (((h == IMG_X0 - 1 || h == IMG_X0 + IW) && v >= IMG_Y0 - 1 && v <= IMG_Y0 + IW) ||
            ((v == IMG_Y0 - 1 || v == IMG_Y0 + IW) && h >= IMG_X0 - 1 && h <= IMG_X0 + IW));
    if (act && in_win(h, v)) return rgb;
    if (act && ring) return 12'hFFF;
    return 12'h000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (tick %0d, cycle %0d)", name, act, exp, k, cyc);
    end
  endtask

  task automatic check_pins();
    if (k == 0) begin
      chk("addr_idle", 32'(vga_addr), 32'd0);
      chk("hsync_idle", 32'(hsync), 32'd1);
      chk("vsync_idle", 32'(vsync), 32'd1);
      chk("rgb_idle", 32'({vga_r, vga_g, vga_b}), 32'd0);
    end else begin
      chk("addr", 32'(vga_addr), 32'(m_addr(k - 1)));
      if (k == 1) begin
        chk("hsync_fill", 32'(hsync), 32'd1);
        chk("vsync_fill", 32'(vsync), 32'd1);
        chk("rgb_fill", 32'({vga_r, vga_g, vga_b}), 32'd0);
      end else begin
        chk("hsync", 32'(hsync), 32'(m_hs(k - 2)));
        chk("vsync", 32'(vsync), 32'(m_vs(k - 2)));
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(m_rgb(k - 2, tick_rgb)));
      end
    end
  endtask

  task automatic clk_step();
    logic [11:0] held;
    bit tick_edge, exp_pt, exp_fs;
    held = {rVGA, gVGA, bVGA};
    @(posedge clk);
    #1;
    cyc++;
    tick_edge = pend;
    if (tick_edge) begin
      k++;
      tick_rgb = held;
    end
    exp_pt = (cyc % CLK_DIV) == CLK_DIV - 1;
    exp_fs = tick_edge && k > 0 && (k % FRAME) == 0;
    chk("pix_tick", 32'(pix_tick), 32'(exp_pt));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    if (tick_edge || (cyc % CLK_DIV) == 2) check_pins();
    if (agg_en) begin
      if (tick_edge && k >= 2 && k < 2 + FRAME) begin
        if (hsync === 1'b0) hs_low++;
        if (vsync === 1'b0) vs_low++;
      end
      if (frame_start === 1'b1) fs_seen++;
    end
    pend = exp_pt;
    if (rand_mode) {rVGA, gVGA, bVGA} = 12'($urandom);
  endtask

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < BUDGET) begin
      clk_step();
      guard++;
    end
    if (k < target) chk("tick_timeout", 32'(k), 32'(target));
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hsync", 32'(hsync), 32'd1);
      chk("rst_vsync", 32'(vsync), 32'd1);
      chk("rst_addr", 32'(vga_addr), 32'd0);
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      chk("rst_pix_tick", 32'(pix_tick), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
    end
    rst = 1'b0;
    cyc = 0;
    k = 0;
    pend = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    {rVGA, gVGA, bVGA} = 12'h000;

    tbl[0]  = '{h: 0,  v: 0,  rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b1, vs: 1'b1, rgb: 12'h000};
    tbl[1]  = '{h: 84, v: 0,  rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b0, vs: 1'b1, rgb: 12'h000};
    tbl[2]  = '{h: 6,  v: 3,  rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b1, vs: 1'b1, rgb: RING};
    tbl[3]  = '{h: 5,  v: 4,  rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b1, vs: 1'b1, rgb: RING};
    tbl[4]  = '{h: 6,  v: 4,  rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b1, vs: 1'b1, rgb: 12'hA53};
    tbl[5]  = '{h: 7,  v: 4,  rgb_in: 12'h5C1, addr: 10'd0,    hs: 1'b1, vs: 1'b1, rgb: 12'h5C1};
    tbl[6]  = '{h: 8,  v: 4,  rgb_in: 12'hA53, addr: 10'd1,    hs: 1'b1, vs: 1'b1, rgb: 12'hA53};
    tbl[7]  = '{h: 70, v: 4,  rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b1, vs: 1'b1, rgb: RING};
    tbl[8]  = '{h: 6,  v: 6,  rgb_in: 12'h3E7, addr: 10'd32,   hs: 1'b1, vs: 1'b1, rgb: 12'h3E7};
    tbl[9]  = '{h: 69, v: 67, rgb_in: 12'hA53, addr: 10'd1023, hs: 1'b1, vs: 1'b1, rgb: 12'hA53};
    tbl[10] = '{h: 70, v: 68, rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b1, vs: 1'b1, rgb: RING};
    tbl[11] = '{h: 40, v: 74, rgb_in: 12'hA53, addr: 10'd0,    hs: 1'b1, vs: 1'b0, rgb: 12'h000};

    do_reset(3);

    agg_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n = tbl[i].v * HT + tbl[i].h;
      {rVGA, gVGA, bVGA} = tbl[i].rgb_in;
      wait_k(n + 1);
      chk($sformatf("vec%0d_addr", i), 32'(vga_addr), 32'(tbl[i].addr));
      wait_k(n + 2);
      chk($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(tbl[i].hs));
      chk($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(tbl[i].vs));
      chk($sformatf("vec%0d_rgb", i), 32'({vga_r, vga_g, vga_b}), 32'(tbl[i].rgb));
    end

    rand_mode = 1'b1;
    wait_k(FRAME + 300);
    agg_en = 1'b0;
    chk("hsync_low_ticks_per_frame", 32'(hs_low), 32'(H_SYNC * VT));
    chk("vsync_low_ticks_per_frame", 32'(vs_low), 32'(V_SYNC * HT));
    chk("frame_start_count", 32'(fs_seen), 32'd1);

    n = FRAME + 30 * HT + 40;
    wait_k(n + 1);
    do_reset(1);
    wait_k(1);
    chk("post_rst_addr", 32'(vga_addr), 32'd0);
    chk("post_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    wait_k(2);
    chk("post_rst_hsync", 32'(hsync), 32'd1);
    chk("post_rst_vsync", 32'(vsync), 32'd1);
    chk("post_rst_rgb_px0", 32'({vga_r, vga_g, vga_b}), 32'd0);
    wait_k(IMG_Y0 * HT + IMG_X0 + 2);
    chk("post_rst_first_window_rgb", 32'({vga_r, vga_g, vga_b}), 32'(tick_rgb));
    wait_k(IMG_Y0 * HT + 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
